// File: rtl/pwm_regs_pkg.sv
// Shared definitions for the PWM generator register path: command byte
// layout, register address width and the SPI command decoder state encoding.
package pwm_regs_pkg;

    localparam int CMD_RW_BIT = 7;
    localparam int CMD_HI_BIT = 6;
    localparam int ADDR_W     = 6;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CMD      = 2'd1,
        RD_FETCH = 2'd2,
        DATA     = 2'd3
    } dec_state_t;

endpackage

// File: rtl/spi_instr_decoder.sv
// SPI command decoder: turns the bridge's byte stream into register-file
// read/write strobes, two bytes per transaction (command, then data).
// For reads the fetched value is parked on data_out so the bridge shifts it
// out on MISO during the second byte.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | cs_n high, no frame in progress
// CMD      | frame open, waiting for a command byte
// RD_FETCH | one cycle: reg_read strobe, capture reg_rdata into data_out
// DATA     | waiting for the data byte (write payload or read dummy)
module spi_instr_decoder #(
    parameter int ADDR_W = pwm_regs_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cs_n,
    input  logic              byte_sync,
    input  logic [7:0]        data_in,
    output logic [7:0]        data_out,
    output logic [ADDR_W-1:0] reg_addr,
    output logic              reg_hi,
    output logic              reg_write,
    output logic [7:0]        reg_wdata,
    output logic              reg_read,
    input  logic [7:0]        reg_rdata
);
    import pwm_regs_pkg::*;

    dec_state_t state;
    dec_state_t next_state;

    logic is_write;
    logic latch_cmd;
    logic write_fire;
    logic read_fire;
    logic data_clear;

    // Next-state and per-cycle control decode; cs_n high overrides everything,
    // so a byte coinciding with the end of a frame is dropped.
    always_comb begin
        next_state = state;
        latch_cmd  = 1'b0;
        write_fire = 1'b0;
        read_fire  = 1'b0;
        data_clear = 1'b0;
        if (cs_n) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    next_state = CMD;
                end
                CMD: begin
                    if (byte_sync) begin
                        latch_cmd  = 1'b1;
                        next_state = data_in[CMD_RW_BIT] ? DATA : RD_FETCH;
                    end
                end
                RD_FETCH: begin
                    read_fire  = 1'b1;
                    next_state = DATA;
                end
                DATA: begin
                    if (byte_sync) begin
                        next_state = CMD;
                        if (is_write) begin
                            write_fire = 1'b1;
                        end else begin
                            data_clear = 1'b1;
                        end
                    end
                end
                default: begin
                    next_state = IDLE;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Command fields, held until the next command byte.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            reg_addr <= '0;
            reg_hi   <= 1'b0;
            is_write <= 1'b0;
        end else if (latch_cmd) begin
            reg_addr <= data_in[ADDR_W-1:0];
            reg_hi   <= data_in[CMD_HI_BIT];
            is_write <= data_in[CMD_RW_BIT];
        end
    end

    // Write strobe and payload land together in the cycle after the data byte.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            reg_write <= 1'b0;
            reg_wdata <= '0;
        end else begin
            reg_write <= write_fire;
            if (write_fire) begin
                reg_wdata <= data_in;
            end
        end
    end

    // MISO byte: loaded from the register file on fetch, cleared once the
    // dummy byte has gone out or the frame ends.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_out <= '0;
        end else if (cs_n || data_clear) begin
            data_out <= '0;
        end else if (read_fire) begin
            data_out <= reg_rdata;
        end
    end

    // Read strobe is valid only in RD_FETCH while the frame is still open, so
    // reg_rdata is sampled in the same cycle it is requested.
    always_comb begin
        reg_read = read_fire;
    end

endmodule
